// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush enables for a 5-stage pipe, miss FSM, perf counters, watchdog.
// Enables are same-cycle combinational; state/counters registered. Misses freeze the pipe until the cache handshakes.
module pipeline_hazard_ctrl #(
  parameter int MISS_TIMEOUT = 255,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_use_hazard,
  input  logic                   branch_mispredict,
  input  logic                   icache_miss,
  input  logic                   icache_ready,
  input  logic                   dcache_miss,
  input  logic                   dcache_ready,
  input  logic                   perf_clr,
  output logic                   pc_write_en,
  output logic                   if_id_write_en,
  output logic                   id_ex_write_en,
  output logic                   ex_mem_write_en,
  output logic                   mem_wb_write_en,
  output logic                   if_id_flush_en,
  output logic                   id_ex_flush_en,
  output logic                   ex_mem_flush_en,
  output logic                   icache_abort,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [15:0]            flush_count,
  output logic                   miss_timeout,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  localparam int WAIT_W = (MISS_TIMEOUT < 2) ? 1 : $clog2(MISS_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MISS_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_HIT = WAIT_W'(MISS_TIMEOUT - 1);

  state_t            state_q;
  state_t            state_nxt;
  logic              i_pend;
  logic [WAIT_W-1:0] wait_cnt;

  logic pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c;
  logic if_id_fl_c, id_ex_fl_c, ex_mem_fl_c, abort_c;
  logic mp_flush, set_ipend;

  always_comb begin
    pc_we_c     = 1'b1;
    if_id_we_c  = 1'b1;
    id_ex_we_c  = 1'b1;
    ex_mem_we_c = 1'b1;
    mem_wb_we_c = 1'b1;
    if_id_fl_c  = 1'b0;
    id_ex_fl_c  = 1'b0;
    ex_mem_fl_c = 1'b0;
    abort_c     = 1'b0;
    mp_flush    = 1'b0;
    set_ipend   = 1'b0;
    state_nxt   = state_q;
    case (state_q)
      RUN: begin
        if (dcache_miss) begin
          {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b00000;
          state_nxt = D_WAIT;
        end else if (branch_mispredict) begin
          {if_id_fl_c, id_ex_fl_c, ex_mem_fl_c} = 3'b111;
          abort_c  = icache_miss;
          mp_flush = 1'b1;
        end else if (icache_miss) begin
          pc_we_c = 1'b0;
          if (load_use_hazard) begin
            if_id_we_c = 1'b0;
            id_ex_fl_c = 1'b1;
          end else begin
            if_id_fl_c = 1'b1;
          end
          state_nxt = I_WAIT;
        end else if (load_use_hazard) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          id_ex_fl_c = 1'b1;
        end
      end
      I_WAIT: begin
        if (dcache_miss) begin
          {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b00000;
          set_ipend = 1'b1;
          state_nxt = D_WAIT;
        end else if (branch_mispredict) begin
          // The redirect kills the outstanding fetch, so the miss is abandoned.
          {if_id_fl_c, id_ex_fl_c, ex_mem_fl_c} = 3'b111;
          abort_c   = 1'b1;
          mp_flush  = 1'b1;
          state_nxt = RUN;
        end else begin
          if (load_use_hazard) begin
            pc_we_c    = 1'b0;
            if_id_we_c = 1'b0;
            id_ex_fl_c = 1'b1;
          end else if (!icache_ready) begin
            pc_we_c    = 1'b0;
            if_id_fl_c = 1'b1;
          end
          if (icache_ready) state_nxt = RUN;
        end
      end
      D_WAIT: begin
        {pc_we_c, if_id_we_c, id_ex_we_c, ex_mem_we_c, mem_wb_we_c} = 5'b00000;
        if (dcache_ready) state_nxt = i_pend ? I_WAIT : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // While in reset the pipe sees the plain "advance" set regardless of the decoded state.
  assign pc_write_en     = pc_we_c     | ~rst_n;
  assign if_id_write_en  = if_id_we_c  | ~rst_n;
  assign id_ex_write_en  = id_ex_we_c  | ~rst_n;
  assign ex_mem_write_en = ex_mem_we_c | ~rst_n;
  assign mem_wb_write_en = mem_wb_we_c | ~rst_n;
  assign if_id_flush_en  = if_id_fl_c  & rst_n;
  assign id_ex_flush_en  = id_ex_fl_c  & rst_n;
  assign ex_mem_flush_en = ex_mem_fl_c & rst_n;
  assign icache_abort    = abort_c     & rst_n;
  assign state           = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      i_pend       <= 1'b0;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
      miss_timeout <= 1'b0;
    end else begin
      state_q <= state_nxt;

      if (set_ipend) i_pend <= 1'b1;
      else if (state_q == D_WAIT && dcache_ready) i_pend <= 1'b0;

      if (state_nxt == RUN) wait_cnt <= '0;
      else if (state_q != RUN && wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);

      // Saturated wait_cnt never re-crosses WAIT_HIT, so a clear stays cleared within one episode.
      if (perf_clr) miss_timeout <= 1'b0;
      else if (state_q != RUN && wait_cnt == WAIT_HIT) miss_timeout <= 1'b1;

      if (perf_clr) stall_cycles <= '0;
      else if (!pc_we_c && stall_cycles != '1) stall_cycles <= stall_cycles + STALL_CNT_W'(1);

      if (perf_clr) flush_count <= '0;
      else if (mp_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against an action-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MT   = 8;
  localparam int SW   = 6;
  localparam int SMAX = (1 << SW) - 1;

  localparam int ACT_NONE   = 0;
  localparam int ACT_FREEZE = 1;
  localparam int ACT_MISP   = 2;
  localparam int ACT_FSTALL = 3;
  localparam int ACT_LUSE   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use_hazard, branch_mispredict, icache_miss, icache_ready;
  logic dcache_miss, dcache_ready, perf_clr;
  logic pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en;
  logic if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, icache_abort;
  logic [SW-1:0] stall_cycles;
  logic [15:0]   flush_count;
  logic          miss_timeout;
  logic [1:0]    state;

  int checks = 0;
  int failures = 0;

  int m_state, m_ipend, m_wait, m_to, m_stall, m_flush;

  pipeline_hazard_ctrl #(.MISS_TIMEOUT(MT), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hazard(load_use_hazard), .branch_mispredict(branch_mispredict),
    .icache_miss(icache_miss), .icache_ready(icache_ready),
    .dcache_miss(dcache_miss), .dcache_ready(dcache_ready), .perf_clr(perf_clr),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .id_ex_write_en(id_ex_write_en),
    .ex_mem_write_en(ex_mem_write_en), .mem_wb_write_en(mem_wb_write_en),
    .if_id_flush_en(if_id_flush_en), .id_ex_flush_en(id_ex_flush_en),
    .ex_mem_flush_en(ex_mem_flush_en), .icache_abort(icache_abort),
    .stall_cycles(stall_cycles), .flush_count(flush_count),
    .miss_timeout(miss_timeout), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // What the pipe must do this cycle, decided from the priority rules of each state.
  function automatic int action(input int st, input logic lu, bm, im, ir, dm);
    if (st == 2) return ACT_FREEZE;
    if (dm) return ACT_FREEZE;
    if (bm) return ACT_MISP;
    if (st == 0) begin
      if (im) return lu ? ACT_LUSE : ACT_FSTALL;
      return lu ? ACT_LUSE : ACT_NONE;
    end
    if (lu) return ACT_LUSE;
    return ir ? ACT_NONE : ACT_FSTALL;
  endfunction

  // {pc, if_id, id_ex, ex_mem, mem_wb write, if_id, id_ex, ex_mem flush, abort}
  function automatic logic [8:0] outs(input int act, input logic ab);
    case (act)
      ACT_FREEZE: return 9'b00000_000_0;
      ACT_MISP:   return {8'b11111_111, ab};
      ACT_FSTALL: return 9'b01111_100_0;
      ACT_LUSE:   return 9'b00111_010_0;
      default:    return 9'b11111_000_0;
    endcase
  endfunction

  function automatic int next_state(input int st, input logic bm, im, ir, dm, dr, input int ipend);
    if (st == 2) return dr ? (ipend != 0 ? 1 : 0) : 2;
    if (dm) return 2;
    if (bm) return 0;
    if (st == 0) return im ? 1 : 0;
    return ir ? 0 : 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_ipend = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".state"}, 64'(state), 64'(m_state));
    chk({tag, ".stall"}, 64'(stall_cycles), 64'(m_stall));
    chk({tag, ".flush"}, 64'(flush_count), 64'(m_flush));
    chk({tag, ".tmo"}, 64'(miss_timeout), 64'(m_to));
  endtask

  // Called at posedge+1: drive, check combinational outputs, clock, check registered state.
  task automatic cyc(input string tag, input logic lu, bm, im, ir, dm, dr, clr);
    int act, nst;
    logic [8:0] e;
    logic ab;
    logic hit;
    load_use_hazard = lu; branch_mispredict = bm; icache_miss = im; icache_ready = ir;
    dcache_miss = dm; dcache_ready = dr; perf_clr = clr;
    #2;
    act = action(m_state, lu, bm, im, ir, dm);
    ab  = (m_state == 1) ? 1'b1 : im;
    e   = outs(act, ab);
    chk({tag, ".outs"}, 64'({pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
        mem_wb_write_en, if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, icache_abort}), 64'(e));
    @(posedge clk);
    nst = next_state(m_state, bm, im, ir, dm, dr, m_ipend);
    if (m_state == 1 && dm) m_ipend = 1;
    else if (m_state == 2 && dr) m_ipend = 0;
    hit = 1'b0;
    if (m_state != 0) begin
      m_wait++;
      if (m_wait == MT) hit = 1'b1;
    end
    if (nst == 0) m_wait = 0;
    if (clr) m_to = 0; else if (hit) m_to = 1;
    if (clr) m_stall = 0; else if (!e[8] && m_stall < SMAX) m_stall++;
    if (clr) m_flush = 0; else if (act == ACT_MISP && m_flush < 65535) m_flush++;
    m_state = nst;
    #1;
    check_regs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    load_use_hazard = 0; branch_mispredict = 0; icache_miss = 0; icache_ready = 0;
    dcache_miss = 1; dcache_ready = 0; perf_clr = 0;
    model_reset();
    #3;
    chk("rst.outs", 64'({pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
        mem_wb_write_en, if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, icache_abort}),
        64'(outs(ACT_NONE, 1'b0)));
    @(posedge clk); #1;
    check_regs("rst");
    rst_n = 1'b1;
    dcache_miss = 0;

    // Single-cycle load-use bubble
    cyc("lu", 1, 0, 0, 0, 0, 0, 0);
    idle("lu_after", 2);
    chk("lu.stall_abs", 64'(stall_cycles), 64'd1);

    // D-miss with ready four cycles later: five frozen cycles
    cyc("clr0", 0, 0, 0, 0, 0, 0, 1);
    cyc("dmiss", 0, 0, 0, 0, 1, 0, 0);
    idle("dwait", 3);
    cyc("dready", 0, 0, 0, 0, 0, 1, 0);
    chk("dmiss.stall_abs", 64'(stall_cycles), 64'd5);

    // Mispredict alongside a fetch miss
    cyc("clr1", 0, 0, 0, 0, 0, 0, 1);
    cyc("misp_im", 0, 1, 1, 0, 0, 0, 0);
    chk("misp.flush_abs", 64'(flush_count), 64'd1);

    // I-miss interrupted by a D-miss, then resumed
    cyc("imiss", 0, 0, 1, 0, 0, 0, 0);
    cyc("iwait", 0, 0, 0, 0, 0, 0, 0);
    cyc("iwait_lu", 1, 0, 0, 0, 0, 0, 0);
    cyc("iw_dmiss", 0, 0, 0, 0, 1, 0, 0);
    cyc("dw_ign", 1, 1, 1, 1, 0, 0, 0);
    cyc("dw_ready", 0, 0, 0, 0, 0, 1, 0);
    chk("ipend.state_abs", 64'(state), 64'd1);
    cyc("iw_ready", 0, 0, 0, 1, 0, 0, 0);
    cyc("imiss_lu", 1, 0, 1, 0, 0, 0, 0);
    cyc("iw_misp", 0, 1, 0, 0, 0, 0, 0);

    // Watchdog: ten D_WAIT cycles, then clear
    cyc("wd_miss", 0, 0, 0, 0, 1, 0, 0);
    idle("wd_wait", 10);
    chk("wd.tmo_abs", 64'(miss_timeout), 64'd1);
    cyc("wd_ready", 0, 0, 0, 0, 0, 1, 0);
    cyc("wd_clr", 1, 0, 0, 0, 0, 0, 1);
    chk("wd.clr_stall_abs", 64'(stall_cycles), 64'd0);
    chk("wd.clr_tmo_abs", 64'(miss_timeout), 64'd0);

    // Stall counter saturation
    for (int i = 0; i < SMAX + 6; i++) cyc("sat", 1, 0, 0, 0, 0, 0, 0);
    chk("sat.stall_abs", 64'(stall_cycles), 64'(SMAX));

    // Asynchronous reset mid-D_WAIT
    cyc("ar_miss", 0, 0, 0, 0, 1, 0, 0);
    idle("ar_wait", 2);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs("ar");
    chk("ar.outs", 64'({pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en,
        mem_wb_write_en, if_id_flush_en, id_ex_flush_en, ex_mem_flush_en, icache_abort}),
        64'(outs(ACT_NONE, 1'b0)));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("ar_after", 1);

    for (int i = 0; i < 3000; i++) begin
      cyc("rand",
          $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 10, $urandom_range(0, 99) < (i % 200 < 100 ? 30 : 3),
          $urandom_range(0, 99) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MISS_TIMEOUT, default 255; miss-wait cycle count at which miss_timeout sets.
REQ-002 Parameter: STALL_CNT_W, default 32; width of stall_cycles.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 load_use_hazard  in  1  ID instruction needs result of the load in EX.
REQ-006 branch_mispredict  in  1  branch resolved in MEM was mispredicted.
REQ-007 icache_miss / icache_ready  in  1 each  fetch miss started / fetch data valid.
REQ-008 dcache_miss / dcache_ready  in  1 each  MEM access miss started / MEM data valid.
REQ-009 perf_clr  in  1  synchronous clear of counters and miss_timeout.
REQ-010 pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en, mem_wb_write_en  out  1 each  stage-register load enables; 0 = hold.
REQ-011 if_id_flush_en, id_ex_flush_en, ex_mem_flush_en  out  1 each  load a bubble; flush overrides write enable.
REQ-012 icache_abort  out  1  drop the outstanding wrong-path fetch.
REQ-013 stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write_en=0.
REQ-014 flush_count  out  16  saturating count of mispredict flushes.
REQ-015 miss_timeout  out  1  sticky watchdog flag.
REQ-016 state  out  2  RUN=0, I_WAIT=1, D_WAIT=2.

Function
REQ-017 Enables, flushes and icache_abort SHALL be combinational from state and inputs (same-cycle stall); state, counters and flag SHALL be registered.
REQ-018 Default, when no rule applies: all write_en=1, all flush_en=0, icache_abort=0.
REQ-019 Whenever a flush_en=1, the same stage's write_en SHALL also be 1.
REQ-020 RUN priority: dcache_miss > branch_mispredict > icache_miss > load_use_hazard.
REQ-021 RUN + dcache_miss: all five write_en=0; next state D_WAIT.
REQ-022 RUN + branch_mispredict: if_id, id_ex and ex_mem flush=1; pc_write_en=1; icache_abort=icache_miss; flush_count+1; stay in RUN.
REQ-023 RUN + icache_miss: pc_write_en=0 and if_id_flush_en=1. If load_use_hazard is also 1, if_id_write_en=0, if_id_flush_en=0 and id_ex_flush_en=1 instead. Next state I_WAIT.
REQ-024 RUN + load_use_hazard only: pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1; one cycle per assertion.
REQ-025 I_WAIT priority: dcache_miss > branch_mispredict > icache_ready.
REQ-026 I_WAIT + dcache_miss: freeze as REQ-021; set i_pend; next state D_WAIT.
REQ-027 I_WAIT + branch_mispredict: apply REQ-022 with icache_abort=1; next state RUN.
REQ-028 I_WAIT + icache_ready: pc_write_en=1 and if_id_write_en=1; next state RUN.
REQ-029 I_WAIT otherwise: pc_write_en=0 and if_id_flush_en=1.
REQ-030 In I_WAIT, load_use_hazard SHALL override the IF/ID action and the PC action: if_id_write_en=0, if_id_flush_en=0, id_ex_flush_en=1, pc_write_en=0.
REQ-031 D_WAIT: all write_en=0 and all flush=0 every cycle, including the dcache_ready cycle. All other inputs are ignored.
REQ-032 D_WAIT + dcache_ready: next state is I_WAIT if i_pend=1 (clear i_pend), else RUN.
REQ-033 Watchdog: wait_cnt SHALL increment each cycle in I_WAIT or D_WAIT and clear on entry to RUN. When wait_cnt reaches MISS_TIMEOUT, miss_timeout SHALL set and remain 1 until perf_clr or reset.
REQ-034 stall_cycles and flush_count SHALL saturate at all-ones and never wrap.
REQ-035 perf_clr SHALL take priority over a same-cycle increment, leaving the counter at 0.

Reset
REQ-036 rst_n=0 SHALL asynchronously force: state=RUN, i_pend=0, wait_cnt=0, stall_cycles=0, flush_count=0, miss_timeout=0.
REQ-037 While rst_n=0, outputs SHALL be the default set of REQ-018.
REQ-038 Reset asserted in I_WAIT or D_WAIT SHALL abandon the miss and require no cache handshake.

Verification
REQ-039 load_use_hazard=1 for 1 cycle in RUN -> pc_write_en=0, if_id_write_en=0, id_ex_flush_en=1 for exactly 1 cycle; stall_cycles=1.
REQ-040 dcache_miss, then dcache_ready 4 cycles later -> all write_en=0 for 5 cycles; state back to RUN; stall_cycles=5.
REQ-041 branch_mispredict with icache_miss in the same RUN cycle -> 3 flushes=1, icache_abort=1, state stays RUN, flush_count=1.
REQ-042 I_WAIT, then dcache_miss, then dcache_ready -> state sequence D_WAIT, then I_WAIT; icache_ready next cycle -> RUN.
REQ-043 MISS_TIMEOUT=8, D_WAIT held 10 cycles -> miss_timeout=1 at cycle 8 and held; perf_clr -> miss_timeout=0, counters=0.
REQ-044 rst_n dropped mid-D_WAIT -> state=RUN and counters=0 immediately, without waiting for a clock edge.
